instr_mem_loader: RTL and testbench

Writer side of the instruction memory: replaces hard-coded initial programs with a run-time load path. Accepts a byte stream (valid/ready), assembles little-endian 32-bit instruction words and drives the memory write port at sequential word addresses. Holds the CPU in reset while loading and pulses done when the program is in place.

---
 rtl/instr_mem_loader_pkg.sv | 16 +
 rtl/instr_mem_loader_word_assembler.sv | 38 +++
 rtl/instr_mem_loader.sv | 146 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared state encoding and widths for the instruction memory loader
package instr_mem_loader_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// rtl/instr_mem_loader_word_assembler.sv - little-endian byte-to-word assembler with byte counter
module instr_mem_loader_word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              byte_fire,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  // New byte enters at the top so after BPW bytes the first byte sits in bits [7:0].
  assign word       = {byte_in, shreg[DATA_W-1:8]};
  assign word_valid = byte_fire && (cnt == CNT_W'(BPW - 1));

  // Shift register and byte-in-word counter; cleared at the start of every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_fire) begin
      shreg <= word;
      cnt   <= word_valid ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - run-time instruction memory loader; optional trailing checksum under LOADER_CHECKSUM_EN
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W,
  parameter int DATA_W = instr_mem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Word counts need one bit beyond the address to hold the full depth, and at
  // least nine bits so any header byte can be compared against the depth.
  localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;

  state_t            state;
  logic [CW-1:0]     n_words;
  logic [CW-1:0]     word_idx;
  logic [CW-1:0]     hdr_n;
  logic              fire;
  logic              word_valid;
  logic [DATA_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign fire  = byte_valid && byte_ready;
  assign hdr_n = CW'(byte_in);

  instr_mem_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      ((state == ST_IDLE) && start),
    .byte_in    (byte_in),
    .byte_fire  (fire && (state == ST_LOAD)),
    .word_valid (word_valid),
    .word       (word)
  );

  // Load sequencer: header, payload words, optional checksum; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      n_words    <= '0;
      word_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_HDR;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            err        <= 1'b0;
            n_words    <= '0;
            word_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        ST_HDR: begin
          if (fire) begin
            if (hdr_n > DEPTH) begin
              state      <= ST_ERR;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              err        <= 1'b1;
            end else begin
              n_words <= (hdr_n == '0) ? DEPTH : hdr_n;
              state   <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (fire) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            if (word_valid) begin
              wr_en    <= 1'b1;
              wr_data  <= word;
              wr_addr  <= word_idx[ADDR_W-1:0];
              word_idx <= word_idx + CW'(1);
              if (word_idx + CW'(1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state      <= ST_DONE;
                byte_ready <= 1'b0;
                cpu_hold   <= 1'b0;
                done       <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (fire) begin
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            if (byte_in == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [5:0]  log_addr [0:511];
  logic [31:0] log_data [0:511];

  instr_mem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every memory write and done pulse away from the active edge.
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_cnt < 512) begin
      log_addr[wr_cnt] = wr_addr;
      log_data[wr_cnt] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (rst_n && done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_in = b;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("byte_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    int base;
    int dbase;
    int bad;
    logic [31:0] exp_w;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // N=2 back-to-back program
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    chk("t2_cpu_hold_loading", 32'(cpu_hold), 32'd1);
    chk("t2_byte_ready_hdr", 32'(byte_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("t2_wr_en_latency", 32'(wr_en), 32'd1);
    send_byte(8'h33); send_byte(8'h01); send_byte(8'h10); send_byte(8'h40);
    chk("t2_last_wr_en", 32'(wr_en), 32'd1);
    chk("t2_last_wr_data", wr_data, 32'h40100133);
`ifdef LOADER_CHECKSUM_EN
    chk("t2_cpu_hold_csum", 32'(cpu_hold), 32'd1);
    send_byte(8'hE1);
`else
    chk("t2_done_with_last_write", 32'(done), 32'd1);
`endif
    cycles(2);
    chk("t2_write_count", 32'(wr_cnt - base), 32'd2);
    chk("t2_addr0", 32'(log_addr[base]), 32'd0);
    chk("t2_data0", log_data[base], 32'h00100093);
    chk("t2_addr1", 32'(log_addr[base+1]), 32'd1);
    chk("t2_data1", log_data[base+1], 32'h40100133);
    chk("t2_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("t2_cpu_hold_after", 32'(cpu_hold), 32'd0);
    chk("t2_err", 32'(err), 32'd0);

    // N=0 full depth with random valid gaps
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      cycles($urandom_range(0, 2));
      send_byte(8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    cycles(3);
    chk("t3_write_count", 32'(wr_cnt - base), 32'd64);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (log_addr[base+k] !== 6'(k) || log_data[base+k] !== exp_w) bad++;
    end
    chk("t3_bad_words", 32'(bad), 32'd0);
    chk("t3_word0", log_data[base], 32'h03020100);
    chk("t3_last_addr", 32'(log_addr[base+63]), 32'd63);
    chk("t3_last_word", log_data[base+63], 32'hFFFEFDFC);
    chk("t3_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("t3_byte_ready_idle", 32'(byte_ready), 32'd0);

    // Header N=65 is too large
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h41);
    chk("t4_err_in_err_state", 32'(err), 32'd1);
    chk("t4_cpu_hold_err", 32'(cpu_hold), 32'd0);
    cycles(2);
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_no_writes", 32'(wr_cnt - base), 32'd0);
    chk("t4_no_done", 32'(done_cnt - dbase), 32'd0);
    chk("t4_byte_ready", 32'(byte_ready), 32'd0);
    pulse_start();
    chk("t4_err_cleared", 32'(err), 32'd0);

    // start mid-LOAD ignored; one word AA BB CC DD
    send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    pulse_start();
    send_byte(8'hCC); send_byte(8'hDD);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    cycles(2);
    chk("t5_write_count", 32'(wr_cnt - base), 32'd1);
    chk("t5_addr", 32'(log_addr[base]), 32'd0);
    chk("t5_data", log_data[base], 32'hDDCCBBAA);
    chk("t5_done_count", 32'(done_cnt - dbase), 32'd1);
    // bytes offered in IDLE
    base = wr_cnt;
    byte_in = 8'h55;
    byte_valid = 1'b1;
    cycles(4);
    chk("t5_idle_byte_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    cycles(1);
    chk("t5_idle_no_writes", 32'(wr_cnt - base), 32'd0);
    chk("t5_idle_cpu_hold", 32'(cpu_hold), 32'd0);

    // Reset during LOAD after two words
    base = wr_cnt;
    pulse_start();
    send_byte(8'h04);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    cycles(1);
    chk("t6_two_words", 32'(wr_cnt - base), 32'd2);
    chk("t6_hold_before_reset", 32'(cpu_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("t6_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("t6_rst_wr_data", wr_data, 32'd0);
    chk("t6_rst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("t6_idle_after_reset", 32'(byte_ready), 32'd0);

    // Single word 01 02 04 08; checksum handling or no extra byte consumed
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h0F);
    cycles(2);
    chk("t7_csum_ok_done", 32'(done_cnt - dbase), 32'd1);
    chk("t7_csum_ok_err", 32'(err), 32'd0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    cycles(2);
    chk("t7_csum_bad_err", 32'(err), 32'd1);
    chk("t7_csum_bad_no_done", 32'(done_cnt - dbase), 32'd1);
    chk("t7_csum_bad_written", 32'(wr_cnt - base), 32'd2);
    chk("t7_csum_bad_data", log_data[base+1], 32'h08040201);
    chk("t7_csum_bad_hold", 32'(cpu_hold), 32'd0);
`else
    chk("t7_done_pulse", 32'(done), 32'd1);
    byte_in = 8'h0F;
    byte_valid = 1'b1;
    cycles(3);
    chk("t7_no_extra_byte", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    cycles(1);
    chk("t7_written", 32'(wr_cnt - base), 32'd1);
    chk("t7_data", log_data[base], 32'h08040201);
    chk("t7_done_count", 32'(done_cnt - dbase), 32'd1);
    chk("t7_err", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
